// File: rtl/top_2_pkg.sv
// Shared definitions for the cache performance experiment: widths, FSM states,
// the fixed access sequence and a saturating-increment helper.
package top_2_pkg;

    localparam int unsigned SEQ_LEN = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned WORD_W  = ADDR_W - 2;
    localparam int unsigned PTR_W   = $clog2(SEQ_LEN);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_LOOKUP = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Byte addresses issued in order; low two bits are ignored by the cache.
    localparam addr_t SEQ_ROM [SEQ_LEN] = '{
        8'h00, 8'h04, 8'h08, 8'h0C, 8'h00, 8'h04, 8'h08, 8'h0C,
        8'h20, 8'h00, 8'h24, 8'h04, 8'h00, 8'h20, 8'h40, 8'h00
    };

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/top_2_if.sv
// Counter bus leaving the cache experiment.
//   clk_count  : cycles spent running the sequence
//   inst_count : accesses completed
//   hit_count  : accesses that hit
// master = producer (top_2), slave = consumer.
interface top_2_if;
    import top_2_pkg::*;

    logic [COUNT_W-1:0] clk_count;
    logic [COUNT_W-1:0] inst_count;
    logic [COUNT_W-1:0] hit_count;

    modport master (output clk_count, output inst_count, output hit_count);
    modport slave  (input  clk_count, input  inst_count, input  hit_count);

endinterface

// File: rtl/top_2_cache_dm.sv
// Direct-mapped, read-only tag store with one word per line.
//   clk, rst : clock, asynchronous active-low reset (clears all valid bits)
//   word_i   : word address being looked up / filled
//   fill_i   : write valid=1 and the tag of word_i into its line this edge
//   hit_c_o  : combinational hit for word_i
module top_2_cache_dm
    import top_2_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    input  logic              fill_i,
    output logic              hit_c_o
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = WORD_W - INDEX_BITS;

    logic [LINES-1:0]            valid_q;
    logic [LINES-1:0][TAG_W-1:0] tag_q;
    logic [INDEX_BITS-1:0]       idx_c;
    logic [TAG_W-1:0]            tag_c;

    assign idx_c   = word_i[INDEX_BITS-1:0];
    assign tag_c   = word_i[WORD_W-1:INDEX_BITS];
    assign hit_c_o = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    // Refill overwrites whatever line the index selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else if (fill_i) begin
            valid_q[idx_c] <= 1'b1;
            tag_q[idx_c]   <= tag_c;
        end
    end

endmodule

// File: rtl/top_2.sv
// Cache performance top: walks the fixed access sequence through a
// direct-mapped cache and counts cycles, completed accesses and hits.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : counter outputs (clk_count, inst_count, hit_count), registered
module top_2
    import top_2_pkg::*;
#(
    parameter int unsigned MISS_PENALTY = 3,
    parameter int unsigned INDEX_BITS   = 3
) (
    input  logic    clk,
    input  logic    rst,
    top_2_if.master bus
);

    localparam int unsigned PEN_W = $clog2(MISS_PENALTY + 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PEN_W-1:0]   pen_q, pen_d;
    logic [COUNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [COUNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [COUNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [WORD_W-1:0]  word_c;
    logic               hit_c;
    logic               fill_c;
    logic               complete_c;

    assign word_c = SEQ_ROM[ptr_q][ADDR_W-1:2];

    top_2_cache_dm #(
        .INDEX_BITS (INDEX_BITS)
    ) u_cache (
        .clk     (clk),
        .rst     (rst),
        .word_i  (word_c),
        .fill_i  (fill_c),
        .hit_c_o (hit_c)
    );

    // Next-state and counter updates.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pen_d      = pen_q;
        clk_cnt_d  = clk_cnt_q;
        inst_cnt_d = inst_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        fill_c     = 1'b0;
        complete_c = 1'b0;

        if (state_q != ST_DONE) begin
            clk_cnt_d = sat_inc(clk_cnt_q);
        end

        case (state_q)
            ST_LOOKUP: begin
                if (hit_c) begin
                    complete_c = 1'b1;
                    hit_cnt_d  = sat_inc(hit_cnt_q);
                end else begin
                    state_d = ST_REFILL;
                    pen_d   = PEN_W'(MISS_PENALTY);
                end
            end
            ST_REFILL: begin
                // pen_q == 1 marks the last penalty cycle: fill and retire.
                if (pen_q == PEN_W'(1)) begin
                    fill_c     = 1'b1;
                    complete_c = 1'b1;
                end else begin
                    pen_d = pen_q - PEN_W'(1);
                end
            end
            default: ;
        endcase

        if (complete_c) begin
            inst_cnt_d = sat_inc(inst_cnt_q);
            if (ptr_q == PTR_W'(SEQ_LEN - 1)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_LOOKUP;
                ptr_d   = ptr_q + PTR_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOOKUP;
            ptr_q      <= '0;
            pen_q      <= '0;
            clk_cnt_q  <= '0;
            inst_cnt_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pen_q      <= pen_d;
            clk_cnt_q  <= clk_cnt_d;
            inst_cnt_q <= inst_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign bus.clk_count  = clk_cnt_q;
    assign bus.inst_count = inst_cnt_q;
    assign bus.hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_top_2.sv
// Self-checking bench for top_2: a penalty-3 instance checked cycle by cycle
// against a trajectory model, plus a penalty-1 instance checked at the end.
module tb_top_2;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    top_2_if bus3 ();
    top_2_if bus1 ();

    top_2 #(.MISS_PENALTY(3), .INDEX_BITS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.master)
    );

    top_2 #(.MISS_PENALTY(1), .INDEX_BITS(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n;

    int unsigned tb_seq [16] = '{'h00, 'h04, 'h08, 'h0C, 'h00, 'h04, 'h08, 'h0C,
                                 'h20, 'h00, 'h24, 'h04, 'h00, 'h20, 'h40, 'h00};

    // Expected counters after each rising edge since reset release (penalty 3).
    int exp_c[$];
    int exp_i[$];
    int exp_h[$];
    int fin1_c, fin1_i, fin1_h;

    logic [23:0] obs3, obs1;
    assign obs3 = {bus3.clk_count, bus3.inst_count, bus3.hit_count};
    assign obs1 = {bus1.clk_count, bus1.inst_count, bus1.hit_count};

    // Cache behaviour from first principles: remember which tag each line holds,
    // charge 1 cycle for a hit and 1+pen for a miss, retire on the last cycle.
    task automatic build_model(input int pen, input bit keep,
                               output int tc, output int ti, output int th);
        int line_tag [8];
        int word, idx, tag, cost;
        bit is_hit;
        foreach (line_tag[k]) line_tag[k] = -1;
        tc = 0; ti = 0; th = 0;
        if (keep) begin exp_c.push_back(0); exp_i.push_back(0); exp_h.push_back(0); end
        for (int a = 0; a < 16; a++) begin
            word   = int'(tb_seq[a]) / 4;
            idx    = word % 8;
            tag    = word / 8;
            is_hit = (line_tag[idx] == tag);
            cost   = is_hit ? 1 : 1 + pen;
            line_tag[idx] = tag;
            for (int k = 1; k <= cost; k++) begin
                tc = (tc < 255) ? tc + 1 : 255;
                if (k == cost) begin
                    ti = (ti < 255) ? ti + 1 : 255;
                    if (is_hit) th = (th < 255) ? th + 1 : 255;
                end
                if (keep) begin exp_c.push_back(tc); exp_i.push_back(ti); exp_h.push_back(th); end
            end
        end
    endtask

    function automatic logic [23:0] exp_at(input int k);
        int j;
        j = (k >= exp_c.size()) ? exp_c.size() - 1 : k;
        return {8'(exp_c[j]), 8'(exp_i[j]), 8'(exp_h[j])};
    endfunction

    task automatic test_reset();
        logic [23:0] want;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs3 !== 24'h0 || obs1 !== 24'h0) begin
                n_bad++;
                $display("FAIL reset_hold: got p3=%h p1=%h, want 000000", obs3, obs1);
            end
        end
        #15 rst = 1'b1;
        edge_n = 0;
        @(negedge clk);
        want = exp_at(0);
        n_cmp++;
        if (obs3 !== want) begin
            n_bad++;
            $display("FAIL reset_release: got %h, want %h", obs3, want);
        end
    endtask

    task automatic test_cold_misses();
        logic [23:0] want;
        while (edge_n < 16) begin
            @(negedge clk);
            edge_n++;
            want = exp_at(edge_n);
            n_cmp++;
            if (obs3 !== want) begin
                n_bad++;
                $display("FAIL cold_cycle%0d: got %h, want %h", edge_n, obs3, want);
            end
        end
        n_cmp++;
        if (obs3 !== {8'd16, 8'd4, 8'd0}) begin
            n_bad++;
            $display("FAIL cold_misses: got clk=%0d inst=%0d hit=%0d, want 16/4/0",
                     obs3[23:16], obs3[15:8], obs3[7:0]);
        end
    endtask

    task automatic test_hits();
        logic [23:0] want;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            edge_n++;
            want = {8'(16 + k), 8'(4 + k), 8'(k)};
            n_cmp++;
            if (obs3 !== want) begin
                n_bad++;
                $display("FAIL warm_hit%0d: got %h, want %h", k, obs3, want);
            end
        end
    endtask

    task automatic test_full_run();
        logic [23:0] want;
        while (edge_n < 49) begin
            @(negedge clk);
            edge_n++;
            want = exp_at(edge_n);
            n_cmp++;
            if (obs3 !== want) begin
                n_bad++;
                $display("FAIL run_cycle%0d: got %h, want %h", edge_n, obs3, want);
            end
        end
        n_cmp++;
        if (obs3 !== {8'd49, 8'd16, 8'd5}) begin
            n_bad++;
            $display("FAIL final_p3: got clk=%0d inst=%0d hit=%0d, want 49/16/5",
                     obs3[23:16], obs3[15:8], obs3[7:0]);
        end
    endtask

    task automatic test_stable();
        int n;
        n = int'($urandom_range(20, 40));
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs3 !== {8'd49, 8'd16, 8'd5}) begin
                n_bad++;
                $display("FAIL done_stable%0d: got %h, want 311005", k, obs3);
            end
        end
    endtask

    task automatic test_penalty1();
        n_cmp++;
        if (obs1 !== {8'd27, 8'd16, 8'd5}) begin
            n_bad++;
            $display("FAIL final_p1: got clk=%0d inst=%0d hit=%0d, want 27/16/5",
                     obs1[23:16], obs1[15:8], obs1[7:0]);
        end
        n_cmp++;
        if (obs1 !== {8'(fin1_c), 8'(fin1_i), 8'(fin1_h)}) begin
            n_bad++;
            $display("FAIL model_p1: got %h, want %0d/%0d/%0d", obs1, fin1_c, fin1_i, fin1_h);
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] want;
        int target;
        bit reached;
        // Abort from DONE, then again mid-run at a random clk_count.
        for (int pass = 0; pass < 2; pass++) begin
            #3 rst = 1'b0;
            #1;
            n_cmp++;
            if (obs3 !== 24'h0 || obs1 !== 24'h0) begin
                n_bad++;
                $display("FAIL async_reset%0d: got p3=%h p1=%h, want 000000", pass, obs3, obs1);
            end
            @(negedge clk);
            #5 rst = 1'b1;
            edge_n  = 0;
            target  = int'($urandom_range(20, 45));
            reached = 1'b0;
            for (int k = 0; k < 100 && !reached; k++) begin
                @(negedge clk);
                edge_n++;
                want = exp_at(edge_n);
                n_cmp++;
                if (obs3 !== want) begin
                    n_bad++;
                    $display("FAIL rerun%0d_cycle%0d: got %h, want %h", pass, edge_n, obs3, want);
                end
                if (pass == 1 && int'(bus3.clk_count) == target) reached = 1'b1;
                if (pass == 0 && edge_n >= 60) reached = 1'b1;
            end
            n_cmp++;
            if (!reached) begin
                n_bad++;
                $display("FAIL rerun%0d_timeout: got clk=%0d, want %0d", pass, bus3.clk_count, target);
            end
        end
        // Final abort: wait out the rerun and confirm the result repeats.
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs3 !== 24'h0 || obs1 !== 24'h0) begin
            n_bad++;
            $display("FAIL async_reset_mid: got p3=%h p1=%h, want 000000", obs3, obs1);
        end
        @(negedge clk);
        #5 rst = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++;
        if (obs3 !== {8'd49, 8'd16, 8'd5}) begin
            n_bad++;
            $display("FAIL rerun_final_p3: got %h, want 311005", obs3);
        end
        n_cmp++;
        if (obs1 !== {8'd27, 8'd16, 8'd5}) begin
            n_bad++;
            $display("FAIL rerun_final_p1: got %h, want 1b1005", obs1);
        end
    endtask

    initial begin
        int tc, ti, th;
        rst = 1'b0;
        build_model(3, 1'b1, tc, ti, th);
        build_model(1, 1'b0, fin1_c, fin1_i, fin1_h);
        test_reset();
        test_cold_misses();
        test_hits();
        test_full_run();
        test_stable();
        test_penalty1();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
